// File: rtl/serdes_pkg.sv
// Shared types and constants for the serializer/deserializer blocks.
package serdes_pkg;

    localparam int unsigned SERDES_DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } serdes_state_t;

    // Bits needed to hold 0..max_value, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_value);
        if (max_value < 2) begin
            return 1;
        end
        return $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/serdes_down_counter.sv
// Loadable down counter that holds at zero and flags when it is there.
module serdes_down_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    // Load takes priority over decrement; the count parks at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: one word per handshake, shifted out MSB first.
module piso_serializer
    import serdes_pkg::*;
#(
    parameter int unsigned WIDTH      = SERDES_DEFAULT_WIDTH,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             done,
    output logic             busy
);

    localparam int unsigned BIT_W    = cnt_width(WIDTH - 1);
    localparam int unsigned GAP_W    = cnt_width(GAP_CYCLES);
    localparam int unsigned GAP_INIT = (GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0;

    serdes_state_t    state;
    logic [WIDTH-1:0] shreg;
    logic [BIT_W-1:0] bit_cnt;
    logic [GAP_W-1:0] gap_cnt_unused;
    logic             bit_zero;
    logic             gap_zero;
    logic             accept;
    logic             bit_load;
    logic             bit_en;
    logic             gap_load;
    logic             gap_en;

    // Handshake decode and counter controls.
    always_comb begin
        load_ready = 1'b0;
        accept     = 1'b0;
        bit_load   = 1'b0;
        bit_en     = 1'b0;
        gap_load   = 1'b0;
        gap_en     = 1'b0;
        case (state)
            IDLE:    load_ready = 1'b1;
            SHIFT:   load_ready = (GAP_CYCLES == 0) && bit_zero;
            default: load_ready = 1'b0;
        endcase
        accept   = load_valid && load_ready;
        bit_load = accept;
        bit_en   = (state == SHIFT) && !accept;
        gap_load = (state == SHIFT) && bit_zero && !accept && (GAP_CYCLES != 0);
        gap_en   = (state == GAP);
    end

    serdes_down_counter #(.CNT_W(BIT_W)) u_bit_cnt (
        .clk        (clk),
        .reset      (reset),
        .load       (bit_load),
        .load_value (BIT_W'(WIDTH - 1)),
        .enable     (bit_en),
        .count      (bit_cnt),
        .zero       (bit_zero)
    );

    // Only the zero flag of the gap counter steers the FSM.
    serdes_down_counter #(.CNT_W(GAP_W)) u_gap_cnt (
        .clk        (clk),
        .reset      (reset),
        .load       (gap_load),
        .load_value (GAP_W'(GAP_INIT)),
        .enable     (gap_en),
        .count      (gap_cnt_unused),
        .zero       (gap_zero)
    );

    // FSM, shift register and registered outputs; outputs show the bit of the coming cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            shreg        <= '0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            frame_start  <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            done        <= 1'b0;
            if (accept) begin
                state        <= SHIFT;
                shreg        <= load_data;
                serial_out   <= load_data[WIDTH-1];
                serial_valid <= 1'b1;
                frame_start  <= 1'b1;
                busy         <= 1'b1;
            end else begin
                case (state)
                    SHIFT: begin
                        shreg <= {shreg[WIDTH-2:0], 1'b0};
                        if (bit_zero) begin
                            serial_out   <= 1'b0;
                            serial_valid <= 1'b0;
                            state        <= (GAP_CYCLES != 0) ? GAP : IDLE;
                            busy         <= (GAP_CYCLES != 0);
                        end else begin
                            serial_out <= shreg[WIDTH-2];
                            done       <= (bit_cnt == BIT_W'(1));
                        end
                    end
                    GAP: begin
                        if (gap_zero) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        serial_out   <= 1'b0;
                        serial_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer with a per-instance bit scoreboard.
module tb_piso_serializer;

    typedef struct packed {
        logic b;
        logic fs;
        logic dn;
    } exp_t;

    logic       clk;
    logic       reset;

    logic [3:0] d0;
    logic       v0, r0, so0, sv0, fs0, dn0, busy0;
    logic [3:0] d1;
    logic       v1, r1, so1, sv1, fs1, dn1, busy1;
    logic [7:0] d2;
    logic       v2, r2, so2, sv2, fs2, dn2, busy2;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int   errors;
    int   checks;
    int   sv_cnt0;
    int   dn_cnt0;
    int   fs_cnt0;
    logic [3:0] sipo;

    piso_serializer #(.WIDTH(4), .GAP_CYCLES(0)) u_w4 (
        .clk(clk), .reset(reset), .load_data(d0), .load_valid(v0), .load_ready(r0),
        .serial_out(so0), .serial_valid(sv0), .frame_start(fs0), .done(dn0), .busy(busy0)
    );

    piso_serializer #(.WIDTH(4), .GAP_CYCLES(2)) u_gap (
        .clk(clk), .reset(reset), .load_data(d1), .load_valid(v1), .load_ready(r1),
        .serial_out(so1), .serial_valid(sv1), .frame_start(fs1), .done(dn1), .busy(busy1)
    );

    piso_serializer #(.WIDTH(8), .GAP_CYCLES(0)) u_w8 (
        .clk(clk), .reset(reset), .load_data(d2), .load_valid(v2), .load_ready(r2),
        .serial_out(so2), .serial_valid(sv2), .frame_start(fs2), .done(dn2), .busy(busy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected bit stream of a word, MSB first, with frame markers.
    task automatic push(input int id, input int w, input logic [7:0] data);
        exp_t e;
        for (int i = w - 1; i >= 0; i--) begin
            e.b  = data[i];
            e.fs = (i == w - 1);
            e.dn = (i == 0);
            case (id)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
    endtask

    task automatic mon_one(input int id, input logic sv, input logic so, input logic fs, input logic dn);
        exp_t e;
        int   n;
        n = (id == 0) ? q0.size() : (id == 1) ? q1.size() : q2.size();
        if (sv) begin
            if (n == 0) begin
                chk($sformatf("d%0d_unexpected_valid", id), 32'(sv), 32'd0);
            end else begin
                case (id)
                    0:       e = q0.pop_front();
                    1:       e = q1.pop_front();
                    default: e = q2.pop_front();
                endcase
                chk($sformatf("d%0d_bit", id), 32'(so), 32'(e.b));
                chk($sformatf("d%0d_frame_start", id), 32'(fs), 32'(e.fs));
                chk($sformatf("d%0d_done", id), 32'(dn), 32'(e.dn));
            end
        end else begin
            chk($sformatf("d%0d_idle_outputs", id), 32'({so, fs, dn}), 32'd0);
        end
    endtask

    task automatic mon();
        mon_one(0, sv0, so0, fs0, dn0);
        mon_one(1, sv1, so1, fs1, dn1);
        mon_one(2, sv2, so2, fs2, dn2);
        if (sv0) begin
            sipo = {sipo[2:0], so0};
            sv_cnt0++;
        end
        if (dn0) dn_cnt0++;
        if (fs0) fs_cnt0++;
    endtask

    // Advance one cycle and sample on the falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        mon();
    endtask

    initial begin
        int   lat;
        logic found;
        errors  = 0;
        checks  = 0;
        sv_cnt0 = 0;
        dn_cnt0 = 0;
        fs_cnt0 = 0;
        sipo    = '0;
        reset   = 1'b1;
        d0 = '0; v0 = 1'b0;
        d1 = '0; v1 = 1'b0;
        d2 = '0; v2 = 1'b0;

        // Reset state
        @(negedge clk);
        cyc();
        cyc();
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_valid", 32'(sv0), 32'd0);
        reset = 1'b0;
        cyc();
        chk("rst_ready_w4", 32'(r0), 32'd1);
        chk("rst_ready_gap", 32'(r1), 32'd1);
        chk("rst_ready_w8", 32'(r2), 32'd1);
        chk("rst_outputs", 32'({so0, sv0, fs0, dn0, busy0}), 32'd0);

        // Single frame 1010 into the SIPO model
        sv_cnt0 = 0; dn_cnt0 = 0; fs_cnt0 = 0;
        d0 = 4'b1010; v0 = 1'b1;
        push(0, 4, 8'h0A);
        cyc();
        v0 = 1'b0; d0 = '0;
        chk("t1_busy", 32'(busy0), 32'd1);
        repeat (5) cyc();
        chk("t1_valid_cycles", 32'(sv_cnt0), 32'd4);
        chk("t1_sipo_word", 32'(sipo), 32'hA);
        chk("t1_drain", 32'(q0.size()), 32'd0);
        chk("t1_idle_busy", 32'(busy0), 32'd0);

        // Back-to-back 1100 then 0011 with valid held
        sv_cnt0 = 0; dn_cnt0 = 0; fs_cnt0 = 0;
        d0 = 4'b1100; v0 = 1'b1;
        push(0, 4, 8'h0C);
        cyc();
        d0 = 4'b0011;
        chk("t2_ready_first_bit", 32'(r0), 32'd0);
        repeat (3) cyc();
        chk("t2_ready_last_bit", 32'(r0), 32'd1);
        push(0, 4, 8'h03);
        cyc();
        v0 = 1'b0; d0 = '0;
        repeat (3) cyc();
        chk("t2_contiguous", 32'(sv_cnt0), 32'd8);
        cyc();
        chk("t2_frame_starts", 32'(fs_cnt0), 32'd2);
        chk("t2_dones", 32'(dn_cnt0), 32'd2);
        chk("t2_drain", 32'(q0.size()), 32'd0);

        // Forced gap of two cycles between frames
        d1 = 4'b1011; v1 = 1'b1;
        push(1, 4, 8'h0B);
        cyc();
        d1 = 4'b0110;
        repeat (3) cyc();
        chk("t3_ready_last_bit", 32'(r1), 32'd0);
        for (int g = 1; g <= 2; g++) begin
            cyc();
            chk($sformatf("t3_gap%0d_valid", g), 32'(sv1), 32'd0);
            chk($sformatf("t3_gap%0d_ready", g), 32'(r1), 32'd0);
            chk($sformatf("t3_gap%0d_busy", g), 32'(busy1), 32'd1);
        end
        cyc();
        chk("t3_idle_ready", 32'(r1), 32'd1);
        chk("t3_idle_busy", 32'(busy1), 32'd0);
        push(1, 4, 8'h06);
        cyc();
        v1 = 1'b0; d1 = '0;
        repeat (4) cyc();
        chk("t3_drain", 32'(q1.size()), 32'd0);

        // Load attempt mid-frame is dropped
        d0 = 4'b1001; v0 = 1'b1;
        push(0, 4, 8'h09);
        cyc();
        d0 = 4'b1111;
        chk("t4_ready_mid", 32'(r0), 32'd0);
        cyc();
        v0 = 1'b0; d0 = '0;
        repeat (4) cyc();
        chk("t4_drain", 32'(q0.size()), 32'd0);
        chk("t4_busy", 32'(busy0), 32'd0);

        // Reset on the second bit aborts the frame
        d0 = 4'b0110; v0 = 1'b1;
        push(0, 4, 8'h06);
        cyc();
        v0 = 1'b0; d0 = '0;
        cyc();
        reset = 1'b1;
        q0.delete();
        dn_cnt0 = 0;
        cyc();
        chk("t5_abort_valid", 32'(sv0), 32'd0);
        chk("t5_abort_busy", 32'(busy0), 32'd0);
        chk("t5_abort_done", 32'(dn_cnt0), 32'd0);
        reset = 1'b0;
        cyc();
        chk("t5_ready_after", 32'(r0), 32'd1);
        d0 = 4'b0101; v0 = 1'b1;
        push(0, 4, 8'h05);
        cyc();
        v0 = 1'b0; d0 = '0;
        repeat (5) cyc();
        chk("t5_drain", 32'(q0.size()), 32'd0);
        chk("t5_dones", 32'(dn_cnt0), 32'd1);
        chk("t5_sipo_word", 32'(sipo), 32'h5);

        // Eight-bit word and done latency
        d2 = 8'hA5; v2 = 1'b1;
        push(2, 8, 8'hA5);
        cyc();
        v2 = 1'b0; d2 = '0;
        lat   = 0;
        found = 1'b0;
        for (int i = 1; i <= 20 && !found; i++) begin
            if (dn2) begin
                lat   = i;
                found = 1'b1;
            end else begin
                cyc();
            end
        end
        chk("t6_done_latency", 32'(lat), 32'd8);
        repeat (2) cyc();
        chk("t6_drain", 32'(q2.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
